// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front-end:
//   NOP_INSTR      - instruction presented to decode when nothing is valid
//   fetch_entry_t  - one buffered fetch result {instr, pc}
//   cnt_width()    - width of counters that must hold the values 0..DEPTH
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // One bit more than the index width, so a full DEPTH count is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO with a registered head; used for the fetched-instruction
// queue and for the request-PC tag FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   push, wdata - write an entry (ignored when full unless popping too)
//   pop         - remove the head (ignored when empty)
//   flush       - drop all entries; wins over push and pop
//   rdata       - current head entry (meaningful when !empty)
//   full, empty, count - occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign rdata     = r_mem[r_rptr];

    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && !flush && (!full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front-end: holds the PC, issues in-order pipelined requests
// to instruction memory under a credit limit, buffers responses and hands them
// to decode over a valid/ready handshake. A redirect flushes the queue and
// discards responses still in flight for the old path.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   imem_req_valid/ready, imem_addr    - request channel (addr == PC register)
//   imem_rsp_valid, imem_rsp_data      - in-order response channel
//   redirect, redirect_pc              - branch/jump redirect from EX
//   instr_valid/ready, instr, instr_pc - head of queue to decode
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW:0]   w_credit_sum;
    logic          w_fire;
    logic          w_rsp;
    logic          w_rsp_keep;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_disc_next;

    fetch_entry_t  w_q_wdata;
    fetch_entry_t  w_q_head;
    logic          w_q_push;
    logic          w_q_pop;
    logic          w_q_full;
    logic          w_q_empty;
    logic [CW-1:0] w_q_count;

    logic [31:0]   w_tag_pc;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic [CW-1:0] w_tag_count;
    logic          w_unused;

    // Request stage: credit uses registered counts only, so a pop this cycle
    // frees a slot one cycle later.
    assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign imem_req_valid = rst_n && !redirect && (w_credit_sum < DEPTH_C);
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign imem_addr      = r_pc;

    // Response stage: a response is only counted against a request we issued.
    // Stale responses (discard != 0) and any response in a redirect cycle
    // are dropped without touching the tag FIFO, which the redirect flushes.
    assign w_rsp      = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp && (r_discard == '0) && !redirect;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fire),
        .wdata (r_pc),
        .pop   (w_rsp_keep),
        .flush (redirect),
        .rdata (w_tag_pc),
        .full  (w_tag_full),
        .empty (w_tag_empty),
        .count (w_tag_count)
    );

    assign w_q_wdata = '{instr: imem_rsp_data, pc: w_tag_pc};
    assign w_q_push  = w_rsp_keep;
    assign w_q_pop   = !w_q_empty && instr_ready && !redirect;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_q_push),
        .wdata (w_q_wdata),
        .pop   (w_q_pop),
        .flush (redirect),
        .rdata (w_q_head),
        .full  (w_q_full),
        .empty (w_q_empty),
        .count (w_q_count)
    );

    // Output stage: registered head only, no bypass from the response.
    assign instr_valid = !w_q_empty;
    assign instr       = instr_valid ? w_q_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? w_q_head.pc    : 32'h0;

    always_comb begin
        w_out_next  = r_outstanding;
        w_disc_next = r_discard;
        if (w_fire) w_out_next = w_out_next + CW'(1);
        if (w_rsp)  w_out_next = w_out_next - CW'(1);
        // Every request still in flight after this cycle belongs to the old
        // path; this also folds in any discard left from an earlier redirect.
        if (redirect) begin
            w_disc_next = r_outstanding - CW'(w_rsp);
        end else if (w_rsp && (r_discard != '0)) begin
            w_disc_next = r_discard - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
            if (redirect) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    assign w_unused = ^{w_tag_full, w_tag_empty, w_tag_count, w_q_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Memory requests in flight, tagged with the fetch path (epoch) they belong to.
    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mreq_t       mem_q[$];
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          epoch    = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          last_due = -1;
    int          checks   = 0;
    int          failures = 0;
    int          dut_pops = 0;

    bit          cap_fire_got;
    bit          cap_valid_got;
    logic [31:0] cap_fire_addr;
    logic [31:0] cap_valid_pc;
    int          cap_valid_cyc;

    function automatic logic [31:0] imem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cap_arm();
        cap_fire_got  = 1'b0;
        cap_valid_got = 1'b0;
        cap_fire_addr = 32'hFFFF_FFFF;
        cap_valid_pc  = 32'hFFFF_FFFF;
        cap_valid_cyc = -1;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req_valid"},   32'(imem_req_valid), 32'd0);
        chk({p, "_imem_addr"},   imem_addr, RESET_PC);
        chk({p, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({p, "_instr"},       instr, NOP_INSTR);
        chk({p, "_instr_pc"},    instr_pc, 32'd0);
    endtask

    task automatic model_reset();
        mem_q.delete();
        mq.delete();
        m_pc     = RESET_PC;
        epoch++;
        last_due = -1;
        cyc      = 0;
    endtask

    // One clock cycle: drive the memory response, compare at the falling edge,
    // then advance the reference model by the rules of the fetch unit.
    task automatic step();
        logic  rsp;
        logic  exp_rv;
        logic  fire;
        mreq_t r;
        int    d;
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? imem_data(mem_q[0].addr) : $urandom();
        @(negedge clk);
        exp_rv = !redirect && ((mem_q.size() + mq.size()) < DEPTH);
        chk("req_valid",   32'(imem_req_valid), 32'(exp_rv));
        chk("imem_addr",   imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        chk("instr",       instr, (mq.size() > 0) ? mq[0].instr : NOP_INSTR);
        chk("instr_pc",    instr_pc, (mq.size() > 0) ? mq[0].pc : 32'd0);
        chk("no_push_full", 32'(dut.w_q_push && dut.w_q_full), 32'd0);
        chk("out_ge_disc",  32'(dut.r_outstanding >= dut.r_discard), 32'd1);
        if (instr_valid && instr_ready && !redirect) dut_pops++;
        if (!cap_valid_got && instr_valid) begin
            cap_valid_got = 1'b1;
            cap_valid_pc  = instr_pc;
            cap_valid_cyc = cyc;
        end
        if (!cap_fire_got && imem_req_valid && imem_req_ready) begin
            cap_fire_got  = 1'b1;
            cap_fire_addr = imem_addr;
        end
        fire = exp_rv && imem_req_ready;
        if ((mq.size() > 0) && instr_ready && !redirect) void'(mq.pop_front());
        if (rsp) begin
            r = mem_q.pop_front();
            if (!redirect && (r.epoch == epoch)) begin
                chk("push_room", 32'(mq.size() < DEPTH), 32'd1);
                mq.push_back('{instr: imem_data(r.addr), pc: r.addr});
            end
        end
        if (fire) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{addr: m_pc, due: d, epoch: epoch});
        end
        if (redirect) begin
            mq.delete();
            epoch++;
            m_pc = redirect_pc & ~32'd3;
        end else if (fire) begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int  exp_disc;
        bit  found;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b1;
        cap_arm();
        #1;
        check_reset("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Streaming with L=1, memory and decode always ready.
        cap_arm();
        dut_pops = 0;
        run(12);
        chk("p1_first_valid_cyc", 32'(cap_valid_cyc), 32'd2);
        chk("p1_first_valid_pc",  cap_valid_pc, RESET_PC);
        chk("p1_first_fire",      cap_fire_addr, RESET_PC);
        chk("p1_pops",            32'(dut_pops), 32'd10);

        // Decode stall: credit stops requests with DEPTH entries held.
        instr_ready = 1'b0;
        run(10);
        chk("p2_q_count",    32'(dut.w_q_count), 32'd4);
        chk("p2_req_stop",   32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        run(12);

        // Memory backpressure holds the address.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0010;
        run(1);
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        run(3);
        chk("p3_hold_addr", imem_addr, 32'h0000_0010);
        imem_req_ready = 1'b1;
        cap_arm();
        run(4);
        chk("p3_first_accept", cap_fire_addr, 32'h0000_0010);

        // Redirect with two requests outstanding at L=3.
        lat            = 3;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && dut.r_outstanding != 0; i++) run(1);
        chk("p4_drained", 32'(dut.r_outstanding), 32'd0);
        imem_req_ready = 1'b1;
        run(2);
        chk("p4_outstanding", 32'(dut.r_outstanding), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        run(1);
        redirect = 1'b0;
        cap_arm();
        run(10);
        chk("p4_first_fire",  cap_fire_addr, 32'h0000_0100);
        chk("p4_first_valid", cap_valid_pc,  32'h0000_0100);

        // Redirect coinciding with a response and a decode pop.
        lat = 2;
        run(6);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_q.size() >= 2 && mem_q[0].due <= cyc && mq.size() > 0) begin
                found = 1'b1;
                break;
            end
            run(1);
        end
        chk("p5_found", 32'(found), 32'd1);
        exp_disc    = mem_q.size() - 1;
        chk("p5_pre_valid", 32'(instr_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        instr_ready = 1'b1;
        run(1);
        redirect = 1'b0;
        chk("p5_discard", 32'(dut.r_discard), 32'(exp_disc));
        chk("p5_empty",   32'(instr_valid), 32'd0);
        run(10);

        // PC wrap and misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF9;
        run(1);
        redirect = 1'b0;
        lat      = 1;
        run(8);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) lat = 1 + int'($urandom_range(3, 0));
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(2, 0) != 0);
            redirect       = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom();
            run(1);
        end
        redirect       = 1'b0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        run(20);

        // Asynchronous reset with a non-empty queue.
        lat         = 1;
        instr_ready = 1'b0;
        run(6);
        chk("p7_nonempty", 32'(instr_valid), 32'd1);
        imem_rsp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("p7");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        instr_ready = 1'b1;
        cap_arm();
        run(8);
        chk("p7_first_fire",      cap_fire_addr, RESET_PC);
        chk("p7_first_valid_pc",  cap_valid_pc, RESET_PC);
        chk("p7_first_valid_cyc", 32'(cap_valid_cyc), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end; sits directly upstream of the decode stage and supplies the 32-bit instr word that decode and control_unit consume.
- Holds the PC, issues pipelined in-order requests to instruction memory, and buffers responses in a small queue.
- Presents instr/PC to decode with a valid/ready handshake.
- On a redirect (taken branch/jump from EX), flushes the queue and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, queue entries; also caps requests outstanding plus queued (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  fetch address; always equals the PC register.
- imem_rsp_valid  input  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect  input  1  pipeline redirect (branch taken / jump).
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0).
- instr_valid  output  1  queue head valid to decode.
- instr_ready  input  1  decode accepts head (low = decode stall).
- instr  output  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
- instr_pc  output  32  PC of head instruction; 0 when instr_valid=0.

Behaviour:
- Reset (async assert, sync deassert by the system): pc=RESET_PC, queue empty, outstanding=0, discard=0. Outputs: imem_req_valid=0 during reset, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0. Reset mid-operation drops all in-flight state; responses arriving afterwards for pre-reset requests are not tracked (memory is reset with the core).
- Credit: imem_req_valid = !redirect && (outstanding + count < DEPTH), using registered counts. A pop in the same cycle does not free credit until the next cycle.
- Request handshake: fire = imem_req_valid && imem_req_ready, then pc <= pc+4 (wraps modulo 2^32) and outstanding++. While valid && !ready, imem_addr is held.
- Response handling: when imem_rsp_valid, outstanding-- (net with fire).
  - If discard>0: drop the response and decrement discard.
  - Otherwise push {imem_rsp_data, pc_of_request}. A shadow queue of request PCs, or a PC tag FIFO, tracks the address per outstanding request.
- Push to a full queue cannot occur by construction; the bench asserts it.
- Pop: instr_valid && instr_ready. Simultaneous push+pop is legal; count is unchanged.
- Latency: request accepted at cycle N, response at N+L, then instr_valid at N+L+1 (no bypass from response to output).
- Throughput: one instruction per cycle sustained when L+1 < DEPTH.
- Redirect (single cycle, highest priority):
  - Queue cleared; the head is not popped even if instr_ready.
  - No request issued that cycle. A request that was valid but not accepted is withdrawn; memory must treat it as not taken.
  - pc <= {redirect_pc[31:2],2'b00}.
  - discard <= outstanding minus any response arriving this cycle. A response arriving in the redirect cycle is dropped.
  - discard accumulates if a second redirect occurs before it drains.
  - Requests resume the next cycle.
- Outstanding counter width is clog2(DEPTH)+1 and never exceeds DEPTH.
- Discard counter has the same width and never underflows; assert outstanding ≥ discard.

Decomposition:
- fetch_pkg: NOP_INSTR (32'h0000_0013), fetch entry struct {instr, pc}, and the width helper for the counters.
- Sub-module fetch_queue: synchronous FIFO with parameters DEPTH and WIDTH and ports push, pop, flush, full, empty, count. It is used twice: once for the instr queue and once for the request-PC tag FIFO.
- The top level holds the PC, credit logic, and discard logic.

Test Plan:
- Reset release, memory L=1 always ready, instr_ready=1 → addr 0,4,8,… issued each cycle; first instr_valid at cycle 2 with instr_pc=0, then one instruction per cycle.
- instr_ready=0 for 10 cycles → requests stop once outstanding+count=4, exactly 4 entries held, no data lost; on release, PCs resume in order with no gaps.
- imem_req_ready=0 for 3 cycles with pc=0x10 → imem_addr stays 0x10 and pc does not advance; the first accepted request is 0x10.
- Redirect to 0x103 with 2 requests outstanding (L=3) → next request addr=0x100; the two stale responses are dropped; first valid instr_pc=0x100.
- Redirect in the same cycle as a response and an instr_ready pop → response discarded, queue empty next cycle, discard = outstanding−1, no pop counted.
- rst_n asserted mid-stream with queue non-empty → instr_valid=0, instr=NOP, imem_addr=RESET_PC immediately (async), fetch restarts from RESET_PC.
